// File: rtl/can_rx_frame_writer_pkg.sv
// Shared definitions for the CAN receive frame writer and its slot ring.
package can_rxw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2,
        DROP   = 2'd3
    } rxwState_t;

    localparam int LEN_OFS  = 0;
    localparam int PAY_OFS  = 1;
    localparam int TS_BYTES = 2;

endpackage

// File: rtl/can_rx_frame_writer_slot_ring.sv
// Slot ring bookkeeping for the CAN frame writer: write slot, read slot and
// the count of committed frames not yet released by the consumer.
module can_rx_slot_ring #(
    parameter int NUM_SLOTS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit,
    input  logic                         frameRelease,
    output logic                         full,
    output logic [$clog2(NUM_SLOTS):0]   count,
    output logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
    output logic [$clog2(NUM_SLOTS)-1:0] rd_slot
);
    localparam int SW = $clog2(NUM_SLOTS);

    logic [SW:0] wrPtr;
    logic [SW:0] rdPtr;
    logic        commitPend;
    logic        relOk;

    // Pointers carry an extra wrap bit so a full ring differs from an empty one.
    assign full    = (wrPtr[SW] != rdPtr[SW]) && (wrPtr[SW-1:0] == rdPtr[SW-1:0]);
    assign wr_slot = wrPtr[SW-1:0];
    assign rd_slot = rdPtr[SW-1:0];
    assign relOk   = frameRelease && (count != '0);

    // wrPtr moves with the length write so a frame starting next cycle gets a
    // fresh slot; count follows one cycle later, once the length byte has landed.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            commitPend <= 1'b0;
        end else begin
            commitPend <= commit;
            if (commit)
                wrPtr <= wrPtr + (SW+1)'(1);
            if (relOk)
                rdPtr <= rdPtr + (SW+1)'(1);
            if (commitPend && !relOk)
                count <= count + (SW+1)'(1);
            else if (!commitPend && relOk)
                count <= count - (SW+1)'(1);
        end
    end

endmodule

// File: rtl/can_rx_frame_writer.sv
// CAN receive frame writer: packs received frames into fixed-size slots of a ring in frame RAM.
// Define CAN_RXW_TIMESTAMP_EN to append a 16-bit receive timestamp to the end of each slot.
module can_rx_frame_writer
    import can_rxw_pkg::*;
#(
    parameter int BASE_ADDR  = 0,
    parameter int SLOT_BYTES = 16,
    parameter int NUM_SLOTS  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_sof,
    input  logic                         in_eof,
    input  logic                         in_abort,
    output logic [15:0]                  addr,
    output logic                         chipSel,
    output logic                         wriEn,
    output logic                         outEn,
    inout  wire  [7:0]                   data,
    output logic [$clog2(NUM_SLOTS):0]   frame_count,
    output logic                         frame_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
    input  logic                         frame_release,
    output logic                         dropped,
    output logic                         overflow
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int OW = $clog2(SLOT_BYTES);
`ifdef CAN_RXW_TIMESTAMP_EN
    localparam int MAX_PAY = SLOT_BYTES - 1 - TS_BYTES;
`else
    localparam int MAX_PAY = SLOT_BYTES - 1;
`endif

    rxwState_t   state, nextState;
    logic [OW:0] payLen;
    logic        accept;
    logic        doWrite, startFrame, dropNow, overflowNow, commitNow;
    logic [OW-1:0] wrOfs;
    logic [7:0]  wrByte;
    logic        full;
    logic [SW-1:0] wrSlot;
    logic [15:0] addrQ;
    logic [7:0]  dataQ;
    logic        wriEnQ, droppedQ, overflowQ;

    function automatic logic [15:0] slotAddr(input logic [SW-1:0] slot, input logic [OW-1:0] ofs);
        return 16'(BASE_ADDR) + (16'(slot) << OW) + 16'(ofs);
    endfunction

    assign in_ready = (state != COMMIT);
    assign accept   = in_valid && in_ready;

`ifdef CAN_RXW_TIMESTAMP_EN
    logic [15:0] tsCnt, tsCap;
    logic [1:0]  commitPhase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tsCnt       <= '0;
            tsCap       <= '0;
            commitPhase <= '0;
        end else begin
            tsCnt <= tsCnt + 16'd1;
            if (startFrame)
                tsCap <= tsCnt;
            commitPhase <= (state == COMMIT && !commitNow) ? commitPhase + 2'd1 : 2'd0;
        end
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        nextState   = state;
        doWrite     = 1'b0;
        wrOfs       = OW'(PAY_OFS) + payLen[OW-1:0];
        wrByte      = in_data;
        startFrame  = 1'b0;
        dropNow     = 1'b0;
        overflowNow = 1'b0;
        commitNow   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !in_abort && in_sof) begin
                    if (full) begin
                        overflowNow = 1'b1;
                        dropNow     = 1'b1;
                        nextState   = in_eof ? IDLE : DROP;
                    end else begin
                        startFrame = 1'b1;
                        doWrite    = 1'b1;
                        wrOfs      = OW'(PAY_OFS);
                        nextState  = in_eof ? COMMIT : WRITE;
                    end
                end
            end
            WRITE: begin
                if (in_abort) begin
                    dropNow   = 1'b1;
                    nextState = IDLE;
                end else if (accept) begin
                    if (in_sof) begin
                        // A new start abandons the partial frame and reuses this slot.
                        startFrame = 1'b1;
                        doWrite    = 1'b1;
                        wrOfs      = OW'(PAY_OFS);
                        nextState  = in_eof ? COMMIT : WRITE;
                    end else if (payLen == (OW+1)'(MAX_PAY)) begin
                        dropNow   = 1'b1;
                        nextState = in_eof ? IDLE : DROP;
                    end else begin
                        doWrite = 1'b1;
                        if (in_eof)
                            nextState = COMMIT;
                    end
                end
            end
            COMMIT: begin
                doWrite = 1'b1;
`ifdef CAN_RXW_TIMESTAMP_EN
                case (commitPhase)
                    2'd0: begin
                        wrOfs  = OW'(SLOT_BYTES - 2);
                        wrByte = tsCap[15:8];
                    end
                    2'd1: begin
                        wrOfs  = OW'(SLOT_BYTES - 1);
                        wrByte = tsCap[7:0];
                    end
                    default: begin
                        wrOfs     = OW'(LEN_OFS);
                        wrByte    = 8'(payLen);
                        commitNow = 1'b1;
                        nextState = IDLE;
                    end
                endcase
`else
                wrOfs     = OW'(LEN_OFS);
                wrByte    = 8'(payLen);
                commitNow = 1'b1;
                nextState = IDLE;
`endif
            end
            DROP: begin
                if (in_abort || (accept && in_eof))
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            payLen    <= '0;
            addrQ     <= 16'(BASE_ADDR);
            dataQ     <= '0;
            wriEnQ    <= 1'b0;
            droppedQ  <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            state    <= nextState;
            wriEnQ   <= doWrite;
            droppedQ <= dropNow;
            if (overflowNow)
                overflowQ <= 1'b1;
            if (doWrite) begin
                addrQ <= slotAddr(wrSlot, wrOfs);
                dataQ <= wrByte;
            end
            if (startFrame)
                payLen <= (OW+1)'(1);
            else if (doWrite && state == WRITE)
                payLen <= payLen + (OW+1)'(1);
        end
    end

    can_rx_slot_ring #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .commit      (commitNow),
        .frameRelease(frame_release),
        .full        (full),
        .count       (frame_count),
        .wr_slot     (wrSlot),
        .rd_slot     (rd_slot)
    );

    assign addr        = addrQ;
    assign chipSel     = wriEnQ;
    assign wriEn       = wriEnQ;
    assign outEn       = 1'b0;
    assign data        = wriEnQ ? dataQ : 8'bz;
    assign dropped     = droppedQ;
    assign overflow    = overflowQ;
    assign frame_valid = (frame_count != '0);

endmodule
